// File: rtl/gm_spi_master.sv
// Single-word full-duplex SPI master with start/done handshake.
// Frame: SETUP (CLK_DIV) -> 2*DATA_WIDTH SCLK half-periods -> HOLD (CLK_DIV).
module gm_spi_master #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk_0,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  SS_n
);

    localparam int EDGES  = 2 * DATA_WIDTH;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(EDGES);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e                  r_state;
    logic [DIV_W-1:0]        r_div;
    logic [EDGE_W-1:0]       r_edge;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_rx;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_ss_n;
    logic                    r_busy;
    logic                    r_done;

    logic w_div_wrap;
    logic w_last_edge;
    logic w_fire;
    logic w_leading;
    logic w_sample;

    assign w_div_wrap  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_edge = (r_edge == EDGE_W'(EDGES - 1));
    // An SCLK edge fires at the start of every SHIFT half-period; edge 0 ends SETUP.
    assign w_fire      = w_div_wrap &&
                         ((r_state == StSetup) || ((r_state == StShift) && !w_last_edge));
    // The upcoming edge index is even (leading) when leaving SETUP or when r_edge is odd.
    assign w_leading   = (r_state == StSetup) || r_edge[0];
    assign w_sample    = w_leading ^ CPHA;

    always_ff @(posedge clk_0 or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_edge  <= '0;
            r_shift <= '0;
            r_rx    <= '0;
            r_sclk  <= CPOL;
            r_mosi  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != StIdle) begin
                r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    r_div  <= '0;
                    r_edge <= '0;
                    if (start) begin
                        r_shift <= tx_data;
                        r_ss_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_sclk  <= CPOL;
                        if (!CPHA) begin
                            r_mosi <= tx_data[DATA_WIDTH-1];
                        end
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    if (w_div_wrap) begin
                        r_edge  <= '0;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    if (w_div_wrap) begin
                        if (w_last_edge) begin
                            r_edge  <= '0;
                            r_state <= StHold;
                        end else begin
                            r_edge <= r_edge + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (w_div_wrap) begin
                        r_ss_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rx    <= r_shift;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_fire) begin
                r_sclk <= ~r_sclk;
                if (w_sample) begin
                    r_shift <= {r_shift[DATA_WIDTH-2:0], MISO};
                end else begin
                    r_mosi <= r_shift[DATA_WIDTH-1];
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx;
    assign SCLK    = r_sclk;
    assign MOSI    = r_mosi;
    assign SS_n    = r_ss_n;

endmodule
